// File: rtl/bus_decoder.sv
// Address decoder and bus bridge: one master, NSLV slaves, with a sticky bus-error log.
// Define BUS_TIMEOUT_EN to add a 16-bit slave-ready timeout (limit set by TIMEOUT).
module bus_decoder #(
    parameter int                 NSLV     = 8,
    parameter logic [NSLV*32-1:0] SLV_BASE = '0,
    parameter logic [NSLV*32-1:0] SLV_MASK = '0,
    parameter int                 TIMEOUT  = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        a,
    input  logic [31:0]        d,
    input  logic               we,
    input  logic               rd,
    output logic [31:0]        spo,
    output logic               ready,
    output logic               irq,
    output logic [31:0]        s_a,
    output logic [31:0]        s_d,
    output logic [NSLV-1:0]    s_we,
    output logic [NSLV-1:0]    s_rd,
    input  logic [32*NSLV-1:0] s_spo,
    input  logic [NSLV-1:0]    s_ready,
    output logic [31:0]        err_addr,
    output logic               err_valid,
    input  logic               err_clr
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

    state_t          state;
    logic [3:0]      sel;
    logic            wr_f;
    logic            hit;
    logic [3:0]      hit_idx;
    logic [NSLV-1:0] hit_oh;
    logic [31:0]     sel_spo;
    logic            sel_rdy;
`ifdef BUS_TIMEOUT_EN
    logic [15:0]     wait_cnt;
`endif

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        hit_oh  = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if ((a & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
                hit       = 1'b1;
                hit_idx   = 4'(i);
                hit_oh    = '0;
                hit_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_spo = '0;
        sel_rdy = 1'b0;
        for (int i = 0; i < NSLV; i++) begin
            if (sel == 4'(i)) begin
                sel_spo = s_spo[32*i +: 32];
                sel_rdy = s_ready[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= '0;
            wr_f      <= 1'b0;
            spo       <= '0;
            ready     <= 1'b0;
            irq       <= 1'b0;
            s_a       <= '0;
            s_d       <= '0;
            s_we      <= '0;
            s_rd      <= '0;
            err_addr  <= '0;
            err_valid <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
        end else begin
            ready <= 1'b0;
            irq   <= 1'b0;
            // A same-cycle error below overrides this clear.
            if (err_clr) err_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (rd | we) begin
                        s_a  <= a;
                        s_d  <= d;
                        wr_f <= we;
                        sel  <= hit_idx;
                        if (hit) begin
                            s_we  <= we ? hit_oh : '0;
                            s_rd  <= we ? '0 : hit_oh;
                            state <= ACCESS;
`ifdef BUS_TIMEOUT_EN
                            wait_cnt <= '0;
`endif
                        end else begin
                            spo   <= ERR_DATA;
                            ready <= 1'b1;
                            irq   <= 1'b1;
                            state <= RESP;
                            if (!err_valid || err_clr) err_addr <= a;
                            err_valid <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    if (sel_rdy) begin
                        spo   <= wr_f ? '0 : sel_spo;
                        s_we  <= '0;
                        s_rd  <= '0;
                        ready <= 1'b1;
                        state <= RESP;
                    end
`ifdef BUS_TIMEOUT_EN
                    // Strobes stay up for exactly TIMEOUT cycles before giving up.
                    else if (wait_cnt == 16'(TIMEOUT - 1)) begin
                        spo   <= ERR_DATA;
                        s_we  <= '0;
                        s_rd  <= '0;
                        ready <= 1'b1;
                        irq   <= 1'b1;
                        state <= RESP;
                        if (!err_valid || err_clr) err_addr <= s_a;
                        err_valid <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
`endif
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_decoder.sv
// Directed bench for bus_decoder: expected responses queued at issue, checked by a ready monitor.
module tb_bus_decoder;

    localparam int NSLV = 2;
    localparam logic [NSLV*32-1:0] BASE = {32'h00000000, 32'h10000000};
    localparam logic [NSLV*32-1:0] MASK = {32'hC0000000, 32'hF0000000};
    localparam logic [31:0] SPO0 = 32'hA5A50000;
    localparam logic [31:0] SPO1 = 32'h5A5A1111;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [31:0]       a, d;
    logic              we, rd;
    logic [31:0]       spo;
    logic              ready, irq;
    logic [31:0]       s_a, s_d;
    logic [NSLV-1:0]   s_we, s_rd;
    logic [32*NSLV-1:0] s_spo;
    logic [NSLV-1:0]   s_ready;
    logic [31:0]       err_addr;
    logic              err_valid;
    logic              err_clr;

    typedef struct {
        logic [31:0] spo;
        logic        irq;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   s1_delay = 0;
    int   s1_cnt   = 0;

    bus_decoder #(.NSLV(NSLV), .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .d(d), .we(we), .rd(rd),
        .spo(spo), .ready(ready), .irq(irq), .s_a(s_a), .s_d(s_d),
        .s_we(s_we), .s_rd(s_rd), .s_spo(s_spo), .s_ready(s_ready),
        .err_addr(err_addr), .err_valid(err_valid), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // Slave 0 is always ready; slave 1 answers after s1_delay strobe cycles.
    assign s_spo = {SPO1, SPO0};
    assign s_ready = {((s_we[1] | s_rd[1]) && s1_cnt == s1_delay), 1'b1};

    always @(posedge clk) begin
        if (s_we[1] | s_rd[1]) s1_cnt <= s1_cnt + 1;
        else                   s1_cnt <= 0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && irq) chk("irq_without_ready", {31'd0, ready}, 32'd1);
        if (rst_n && ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_ready", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("spo", spo, e.spo);
                chk("irq", {31'd0, irq}, {31'd0, e.irq});
            end
        end
    end

    // Issue one request at a negedge and watch it until ready, counting strobe cycles.
    task automatic req(input logic [31:0] addr, input logic [31:0] dat, input logic w, input logic r,
                       input int dly1, input logic [31:0] xspo, input logic xirq,
                       input int xlat, input int xstrb, input int slv, input logic scramble,
                       input logic clr);
        int lat = 0;
        int nstrb = 0;
        int stray = 0;
        logic [NSLV-1:0] exp_oh;
        logic [NSLV-1:0] cur;
        exp_t e;
        exp_oh = (slv >= 0) ? NSLV'(1 << slv) : '0;
        s1_delay = dly1;
        a = addr; d = dat; we = w; rd = r; err_clr = clr;
        e.spo = xspo; e.irq = xirq;
        sb.push_back(e);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) begin
                err_clr = 1'b0;
                if (scramble) begin a = 32'h70000000; d = ~dat; end
            end
            cur = w ? s_we : s_rd;
            if ((cur & exp_oh) != '0) nstrb++;
            if (((s_we | s_rd) & ~(cur & exp_oh)) != '0) stray++;
            if (ready) begin lat = k; break; end
        end
        we = 1'b0; rd = 1'b0;
        chk("latency", lat, xlat);
        chk("strobe_cycles", nstrb, xstrb);
        chk("stray_strobes", stray, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int nrdy;
        int nstrb;
        rst_n = 1'b0; a = '0; d = '0; we = 1'b0; rd = 1'b0; err_clr = 1'b0;
        #1;
        chk("rst_spo", spo, 32'd0);
        chk("rst_ready_irq", {30'd0, ready, irq}, 32'd0);
        chk("rst_s_a", s_a, 32'd0);
        chk("rst_strobes", {28'd0, s_we, s_rd}, 32'd0);
        chk("rst_err", {err_valid, err_addr[30:0]}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // read hit on slave 0, always ready
        req(32'h10000010, 32'h0, 1'b0, 1'b1, 0, SPO0, 1'b0, 2, 1, 0, 1'b0, 1'b0);
        @(negedge clk);
        // write to slave 1, ready after 5 cycles, master bus scrambled mid-access
        req(32'h20000004, 32'hCAFE0001, 1'b1, 1'b0, 5, 32'd0, 1'b0, 7, 6, 1, 1'b1, 1'b0);
        chk("s_a_held", s_a, 32'h20000004);
        chk("s_d_held", s_d, 32'hCAFE0001);
        chk("no_err_after_write", {31'd0, err_valid}, 32'd0);
        @(negedge clk);
        req(32'h20000004, 32'h0, 1'b0, 1'b1, 0, SPO1, 1'b0, 2, 1, 1, 1'b0, 1'b0);
        // held back-to-back: one-cycle turnaround adds a cycle
        req(32'h20000004, 32'h0, 1'b0, 1'b1, 0, SPO1, 1'b0, 3, 1, 1, 1'b0, 1'b0);
        @(negedge clk);
        // rd and we together is a write
        req(32'h10000020, 32'h12345678, 1'b1, 1'b1, 0, 32'd0, 1'b0, 2, 1, 0, 1'b0, 1'b0);
        @(negedge clk);
        // decode misses
        req(32'h70000000, 32'h0, 1'b0, 1'b1, 0, 32'hDEADBEEF, 1'b1, 1, 0, -1, 1'b0, 1'b0);
        chk("err_addr_first", err_addr, 32'h70000000);
        chk("err_valid_set", {31'd0, err_valid}, 32'd1);
        @(negedge clk);
        req(32'h80000000, 32'h0, 1'b0, 1'b1, 0, 32'hDEADBEEF, 1'b1, 1, 0, -1, 1'b0, 1'b0);
        chk("err_addr_sticky", err_addr, 32'h70000000);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_clr", {31'd0, err_valid}, 32'd0);
        // overlapping windows: slave 0 wins
        req(32'h10000000, 32'h0, 1'b0, 1'b1, 0, SPO0, 1'b0, 2, 1, 0, 1'b0, 1'b0);
        @(negedge clk);
        // miss with err_clr asserted the same cycle: error wins, address reloads
        req(32'h70000000, 32'h0, 1'b0, 1'b1, 0, 32'hDEADBEEF, 1'b1, 1, 0, -1, 1'b0, 1'b0);
        @(negedge clk);
        req(32'h90000000, 32'h0, 1'b0, 1'b1, 0, 32'hDEADBEEF, 1'b1, 1, 0, -1, 1'b0, 1'b1);
        chk("clr_vs_err_valid", {31'd0, err_valid}, 32'd1);
        chk("clr_vs_err_addr", err_addr, 32'h90000000);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
`ifdef BUS_TIMEOUT_EN
        req(32'h20000008, 32'h0, 1'b0, 1'b1, 1000000, 32'hDEADBEEF, 1'b1, 5, 4, 1, 1'b0, 1'b0);
        chk("timeout_err_valid", {31'd0, err_valid}, 32'd1);
        chk("timeout_err_addr", err_addr, 32'h20000008);
        @(negedge clk);
`endif
        // slave never ready, reset mid-access, request held across release
        s1_delay = 1000000;
        a = 32'h20000000; rd = 1'b1;
        nrdy = 0; nstrb = 0;
`ifdef BUS_TIMEOUT_EN
        repeat (2) begin
`else
        repeat (20) begin
`endif
            @(negedge clk);
            if (ready) nrdy++;
            if (s_rd[1]) nstrb++;
        end
        chk("stall_no_ready", nrdy, 0);
`ifdef BUS_TIMEOUT_EN
        chk("stall_strobe", nstrb, 2);
`else
        chk("stall_strobe", nstrb, 20);
`endif
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_strobes", {28'd0, s_we, s_rd}, 32'd0);
        chk("async_rst_s_a", s_a, 32'd0);
        chk("async_rst_spo", spo, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        req(32'h20000000, 32'h0, 1'b0, 1'b1, 2, SPO1, 1'b0, 4, 3, 1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
